// File: rtl/alu_multiciclo.sv
// Multicycle ALU: single-cycle arithmetic/logic/compare/branch results, iterative shifts.
// Define ALU_SHIFT4_EN to shift 4 bits per cycle while at least 4 remain.
module alu_multiciclo #(
   parameter int W       = 32,
   parameter int SHAMT_W = $clog2(W)
) (
   input  logic               CLK,
   input  logic               RSTa,
   input  logic               start,
   input  logic [3:0]         ALUcontrol,
   input  logic [W-1:0]       A,
   input  logic [W-1:0]       B,
   output logic               busy,
   output logic               done,
   output logic [W-1:0]       resultado,
   output logic               zero
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_BNE  = 4'b0011;
   localparam logic [3:0] OP_SLT  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_XOR  = 4'b1001;
   localparam logic [3:0] OP_SRL  = 4'b1010;
   localparam logic [3:0] OP_LUI  = 4'b1100;
   localparam logic [3:0] OP_SLTU = 4'b1101;
   localparam logic [3:0] OP_SRA  = 4'b1110;
   localparam logic [3:0] OP_BEQ  = 4'b1111;

   typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

   state_t               state, state_nxt;
   logic [3:0]           op_p0;
   logic [W-1:0]         acc_p0;
   logic [SHAMT_W-1:0]   cnt_p0;

   logic                 accept, is_shift, launch_shift, launch_alu, last_step;
   logic [SHAMT_W-1:0]   shamt, step_amt, cnt_nxt;
   logic [W-1:0]         alu_res, acc_nxt;

   function automatic logic [W-1:0] alu_op(input logic [3:0] ctrl,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      logic signed [W-1:0] sa;
      logic signed [W-1:0] sb;
      logic [W-1:0]        r;
      sa = $signed(a);
      sb = $signed(b);
      r  = '0;
      case (ctrl)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_OR:   r = a | b;
         OP_AND:  r = a & b;
         OP_XOR:  r = a ^ b;
         OP_SLT:  r = {{(W-1){1'b0}}, (sa < sb)};
         OP_SLTU: r = {{(W-1){1'b0}}, (a < b)};
         OP_LUI:  r = b;
         OP_BEQ:  r = a - b;
         OP_BNE:  r = {{(W-1){1'b0}}, (a == b)};
         // Shift codes only reach here with a zero shift amount.
         OP_SLL, OP_SRL, OP_SRA: r = a;
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [W-1:0] shift_by(input logic [3:0] ctrl,
                                             input logic [W-1:0] v,
                                             input logic [SHAMT_W-1:0] n);
      logic signed [W-1:0] sv;
      logic [W-1:0]        r;
      sv = $signed(v);
      case (ctrl)
         OP_SLL:  r = v << n;
         OP_SRL:  r = v >> n;
         default: r = sv >>> n;
      endcase
      return r;
   endfunction

   assign busy     = (state == SHIFT);
   assign shamt    = B[SHAMT_W-1:0];
   assign is_shift = (ALUcontrol == OP_SLL) || (ALUcontrol == OP_SRL) ||
                     (ALUcontrol == OP_SRA);
   assign accept       = start && !busy;
   assign launch_shift = accept && is_shift && (shamt != '0);
   assign launch_alu   = accept && !launch_shift;
   assign alu_res      = alu_op(ALUcontrol, A, B);

`ifdef ALU_SHIFT4_EN
   assign step_amt = (cnt_p0 >= SHAMT_W'(4)) ? SHAMT_W'(4) : SHAMT_W'(1);
`else
   assign step_amt = SHAMT_W'(1);
`endif
   assign acc_nxt   = shift_by(op_p0, acc_p0, step_amt);
   assign cnt_nxt   = cnt_p0 - step_amt;
   assign last_step = (state == SHIFT) && (cnt_nxt == '0);

   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) state <= IDLE;
      else       state <= state_nxt;
   end

   // FIN behaves like IDLE for acceptance so a start in the done cycle is taken.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, FIN: state_nxt = launch_shift ? SHIFT : IDLE;
         SHIFT:     state_nxt = last_step ? FIN : SHIFT;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         cnt_p0    <= '0;
         done      <= 1'b0;
         resultado <= '0;
         zero      <= 1'b1;
      end else begin
         done <= launch_alu || last_step;
         if (launch_shift)       cnt_p0 <= shamt;
         else if (state == SHIFT) cnt_p0 <= cnt_nxt;
         if (launch_alu) begin
            resultado <= alu_res;
            zero      <= (alu_res == '0);
         end else if (last_step) begin
            resultado <= acc_nxt;
            zero      <= (acc_nxt == '0);
         end
      end
   end

   // Operand capture and shift accumulator
   always_ff @(posedge CLK) begin
      if (launch_shift) begin
         acc_p0 <= A;
         op_p0  <= ALUcontrol;
      end else if (state == SHIFT) begin
         acc_p0 <= acc_nxt;
      end
   end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed table-driven bench for alu_multiciclo plus multicycle corner sequences.
module tb_alu_multiciclo;

   logic        CLK = 1'b0;
   logic        RSTa;
   logic        start;
   logic [3:0]  ALUcontrol;
   logic [31:0] A, B;
   logic        busy, done, zero;
   logic [31:0] resultado;

   int n_checks = 0;
   int n_fail   = 0;

   alu_multiciclo #(.W(32)) dut (
      .CLK(CLK), .RSTa(RSTa), .start(start), .ALUcontrol(ALUcontrol),
      .A(A), .B(B), .busy(busy), .done(done), .resultado(resultado), .zero(zero)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      string       name;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic [3:0] c, input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      if (!(c == 4'b1000 || c == 4'b1010 || c == 4'b1110) || sh == 0) return 1;
`ifdef ALU_SHIFT4_EN
      return 1 + sh / 4 + sh % 4;
`else
      return sh + 1;
`endif
   endfunction

   task automatic run_op(input vec_t v);
      int lat, busy_cnt;
      @(negedge CLK);
      ALUcontrol = v.ctrl; A = v.a; B = v.b; start = 1'b1;
      @(negedge CLK);
      start = 1'b0; A = $urandom; B = $urandom; ALUcontrol = 4'($urandom);
      lat = 1; busy_cnt = 0;
      while (!done && lat < 100) begin
         if (busy) busy_cnt++;
         @(negedge CLK);
         lat++;
      end
      check({v.name, " done_seen"}, 32'(done), 32'd1);
      check({v.name, " latency"}, lat, exp_lat(v.ctrl, v.b));
      check({v.name, " busy_cycles"}, busy_cnt, exp_lat(v.ctrl, v.b) - 1);
      check({v.name, " busy_at_done"}, 32'(busy), 32'd0);
      check({v.name, " resultado"}, resultado, v.res);
      check({v.name, " zero"}, 32'(zero), 32'(v.z));
      @(negedge CLK);
      check({v.name, " done_pulse"}, 32'(done), 32'd0);
      check({v.name, " hold"}, resultado, v.res);
   endtask

   initial begin
      int first_done, n_done;
      vecs[0]  = '{4'b0000, 32'd5,          32'd7,          32'd12,         1'b0, "add"};
      vecs[1]  = '{4'b0111, 32'd3,          32'd5,          32'hFFFFFFFE,   1'b0, "sub"};
      vecs[2]  = '{4'b0001, 32'hF0,         32'h0F,         32'hFF,         1'b0, "or"};
      vecs[3]  = '{4'b0010, 32'hF0,         32'h3C,         32'h30,         1'b0, "and"};
      vecs[4]  = '{4'b1001, 32'hFF,         32'hFF,         32'h0,          1'b1, "xor"};
      vecs[5]  = '{4'b0100, 32'hFFFFFFFF,   32'd1,          32'd1,          1'b0, "slt"};
      vecs[6]  = '{4'b1101, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1, "sltu"};
      vecs[7]  = '{4'b1100, 32'h123,        32'hABCD0000,   32'hABCD0000,   1'b0, "lui"};
      vecs[8]  = '{4'b1111, 32'd9,          32'd9,          32'd0,          1'b1, "beq_eq"};
      vecs[9]  = '{4'b0011, 32'd9,          32'd9,          32'd1,          1'b0, "bne_eq"};
      vecs[10] = '{4'b0011, 32'd9,          32'd8,          32'd0,          1'b1, "bne_ne"};
      vecs[11] = '{4'b0101, 32'd5,          32'd5,          32'd0,          1'b1, "unused"};
      vecs[12] = '{4'b1110, 32'h80000000,   32'd4,          32'hF8000000,   1'b0, "sra4"};
      vecs[13] = '{4'b1000, 32'd3,          32'd2,          32'hC,          1'b0, "sll2"};
      vecs[14] = '{4'b1010, 32'hF0,         32'd4,          32'h0F,         1'b0, "srl4"};
      vecs[15] = '{4'b1010, 32'h1234,       32'h20,         32'h1234,       1'b0, "shamt0"};
      vecs[16] = '{4'b1110, 32'h80000000,   32'd5,          32'hFC000000,   1'b0, "sra5"};
      vecs[17] = '{4'b1000, 32'h1,          32'd7,          32'h80,         1'b0, "sll7"};

      start = 1'b0; ALUcontrol = '0; A = '0; B = '0;
      RSTa = 1'b0;
      repeat (2) @(negedge CLK);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst resultado", resultado, 32'd0);
      check("rst zero", 32'(zero), 32'd1);
      RSTa = 1'b1;

      for (int i = 0; i < 18; i++) run_op(vecs[i]);

      // SLL 1<<31 with an ADD start pulsed while busy: must be ignored
      @(negedge CLK);
      ALUcontrol = 4'b1000; A = 32'd1; B = 32'd31; start = 1'b1;
      first_done = 0; n_done = 0;
      for (int c = 1; c <= 45; c++) begin
         @(negedge CLK);
         start = (c == 3);
         if (c == 3) begin ALUcontrol = 4'b0000; A = 32'd1; B = 32'd1; end
         if (done) begin
            n_done++;
            if (first_done == 0) begin
               first_done = c;
               check("sll31 resultado", resultado, 32'h80000000);
            end
         end
      end
      check("sll31 latency", first_done, exp_lat(4'b1000, 32'd31));
      check("sll31 done_count", n_done, 1);

      // SRL aborted by reset mid-shift
      @(negedge CLK);
      ALUcontrol = 4'b1010; A = 32'hFFFFFFFF; B = 32'd16; start = 1'b1;
      n_done = 0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge CLK);
         start = 1'b0;
         if (done) n_done++;
      end
      RSTa = 1'b0;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort resultado", resultado, 32'd0);
      check("abort zero", 32'(zero), 32'd1);
      repeat (2) @(negedge CLK);
      RSTa = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         if (done) n_done++;
      end
      check("abort no_done", n_done, 0);
      check("abort resultado_held", resultado, 32'd0);
      run_op('{4'b0000, 32'd1, 32'd1, 32'd2, 1'b0, "add_after_rst"});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
